// File: rtl/control_constants.sv
// rtl/control_constants.sv - shared opcodes, select codes, FSM states and trap causes
package control_constants;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] INST3_BEQ  = 3'b000;
  localparam logic [2:0] INST3_BNE  = 3'b001;
  localparam logic [2:0] INST3_BLT  = 3'b100;
  localparam logic [2:0] INST3_BGE  = 3'b101;
  localparam logic [2:0] INST3_BLTU = 3'b110;
  localparam logic [2:0] INST3_BGEU = 3'b111;

  localparam logic [2:0] INST3_ADD_SUB = 3'b000;
  localparam logic [2:0] INST3_SLL     = 3'b001;
  localparam logic [2:0] INST3_SLT     = 3'b010;
  localparam logic [2:0] INST3_SLTU    = 3'b011;
  localparam logic [2:0] INST3_XOR     = 3'b100;
  localparam logic [2:0] INST3_SRL_SRA = 3'b101;
  localparam logic [2:0] INST3_OR      = 3'b110;
  localparam logic [2:0] INST3_AND     = 3'b111;

  localparam logic [1:0] CTL_PC_PLUS4 = 2'd0;
  localparam logic [1:0] CTL_PC_IMM   = 2'd1;
  localparam logic [1:0] CTL_PC_ALU   = 2'd2;

  localparam logic CTL_ALU_A_RS1 = 1'b0;
  localparam logic CTL_ALU_A_PC  = 1'b1;
  localparam logic CTL_ALU_B_RS2 = 1'b0;
  localparam logic CTL_ALU_B_IMM = 1'b1;

  localparam logic [1:0] CTL_WB_ALU = 2'd0;
  localparam logic [1:0] CTL_WB_MEM = 2'd1;
  localparam logic [1:0] CTL_WB_PC4 = 2'd2;

  localparam logic [1:0] CTL_TRAP_NONE    = 2'd0;
  localparam logic [1:0] CTL_TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] CTL_TRAP_IMEM_TO = 2'd2;
  localparam logic [1:0] CTL_TRAP_DMEM_TO = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [2:0] {
    CTL_ST_IDLE   = 3'd0,
    CTL_ST_FETCH  = 3'd1,
    CTL_ST_DECODE = 3'd2,
    CTL_ST_EXEC   = 3'd3,
    CTL_ST_MEM    = 3'd4,
    CTL_ST_WB     = 3'd5,
    CTL_ST_TRAP   = 3'd6
  } ctl_state_e;

  // funct7 selecting SUB / SRA; any other pattern means the base operation
  function automatic logic is_alt_funct7(input logic [6:0] funct7);
    return funct7 == 7'b0100000;
  endfunction

endpackage

// File: rtl/alu_op_gen.sv
// rtl/alu_op_gen.sv - maps opcode/funct3/funct7 to the ALU operation code
module alu_op_gen
  import control_constants::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic [3:0] op;
  logic       alt;

  assign alt = is_alt_funct7(funct7);

  always_comb begin
    op = ALU_ADD;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3)
          INST3_ADD_SUB: op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
          INST3_SLL:     op = ALU_SLL;
          INST3_SLT:     op = ALU_SLT;
          INST3_SLTU:    op = ALU_SLTU;
          INST3_XOR:     op = ALU_XOR;
          INST3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
          INST3_OR:      op = ALU_OR;
          INST3_AND:     op = ALU_AND;
          default:       op = ALU_ADD;
        endcase
      end
      // branches compare through the ALU; the FSM reads only alu_zero
      OPC_BRANCH: begin
        case (funct3)
          INST3_BEQ, INST3_BNE:   op = ALU_SUB;
          INST3_BLT, INST3_BGE:   op = ALU_SLT;
          INST3_BLTU, INST3_BGEU: op = ALU_SLTU;
          default:                op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign alu_op = ALU_OP_W'(op);

endmodule

// File: rtl/controlpath_multi.sv
// rtl/controlpath_multi.sv - multi-cycle RV32I control FSM with memory timeout and sticky trap
// Optional CTL_JUMP_EN: makes JAL/JALR legal instructions.
module controlpath_multi
  import control_constants::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          inst_opcode,
  input  logic [2:0]          inst_funct3,
  input  logic [6:0]          inst_funct7,
  input  logic                alu_zero,
  input  logic                imem_ready,
  input  logic                mem_ready,
  output logic                imem_rd_en,
  output logic                ir_wren,
  output logic                pc_wren,
  output logic [1:0]          sel_next_pc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_op_a_sel,
  output logic                alu_op_b_sel,
  output logic                reg_file_wen,
  output logic [1:0]          wb_sel,
  output logic                mem_rd_en,
  output logic                mem_wr_en,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  ctl_state_e          state_q, state_d;
  logic [1:0]          cause_d;
  logic [1:0]          trap_cause_q;
  logic                trap_q;
  logic [TO_W-1:0]     cnt_q;
  logic [ALU_OP_W-1:0] gen_alu_op;
  logic                is_load, is_jal, is_jalr, is_jump;
  logic                alu_hold, waiting, to_hit;

  function automatic logic inst_legal(input logic [6:0] opc, input logic [2:0] f3);
    logic ok;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM: ok = 1'b1;
      OPC_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
`ifdef CTL_JUMP_EN
      OPC_JAL:    ok = 1'b1;
      OPC_JALR:   ok = (f3 == 3'b000);
`endif
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // BLT/BLTU: ALU gives SLT, so nonzero result means taken; BGE/BGEU inverse
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    logic t;
    case (f3)
      INST3_BEQ, INST3_BGE, INST3_BGEU: t = zero;
      INST3_BNE, INST3_BLT, INST3_BLTU: t = !zero;
      default:                          t = 1'b0;
    endcase
    return t;
  endfunction

  alu_op_gen #(
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_op_gen (
    .opcode (inst_opcode),
    .funct3 (inst_funct3),
    .funct7 (inst_funct7),
    .alu_op (gen_alu_op)
  );

  assign is_load  = (inst_opcode == OPC_LOAD);
  assign is_jal   = (inst_opcode == OPC_JAL);
  assign is_jalr  = (inst_opcode == OPC_JALR);
  assign is_jump  = is_jal || is_jalr;

  // ALU controls stay valid from EXEC through WB so the address/result is stable
  assign alu_hold     = state_q inside {CTL_ST_EXEC, CTL_ST_MEM, CTL_ST_WB};
  assign alu_op       = alu_hold ? gen_alu_op : '0;
  assign alu_op_a_sel = (alu_hold && is_jal) ? CTL_ALU_A_PC : CTL_ALU_A_RS1;
  assign alu_op_b_sel = (alu_hold && inst_opcode != OPC_OP && inst_opcode != OPC_BRANCH)
                        ? CTL_ALU_B_IMM : CTL_ALU_B_RS2;

  assign waiting = ((state_q == CTL_ST_FETCH) && !imem_ready) ||
                   ((state_q == CTL_ST_MEM) && !mem_ready);
  assign to_hit  = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    cause_d      = CTL_TRAP_NONE;
    imem_rd_en   = 1'b0;
    ir_wren      = 1'b0;
    pc_wren      = 1'b0;
    sel_next_pc  = CTL_PC_PLUS4;
    reg_file_wen = 1'b0;
    wb_sel       = CTL_WB_ALU;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    case (state_q)
      CTL_ST_IDLE: state_d = CTL_ST_FETCH;
      CTL_ST_FETCH: begin
        imem_rd_en = 1'b1;
        if (imem_ready) begin
          ir_wren = 1'b1;
          state_d = CTL_ST_DECODE;
        end else if (to_hit) begin
          state_d = CTL_ST_TRAP;
          cause_d = CTL_TRAP_IMEM_TO;
        end
      end
      CTL_ST_DECODE: begin
        if (inst_legal(inst_opcode, inst_funct3)) begin
          state_d = CTL_ST_EXEC;
        end else begin
          state_d = CTL_ST_TRAP;
          cause_d = CTL_TRAP_ILLEGAL;
        end
      end
      CTL_ST_EXEC: begin
        case (inst_opcode)
          OPC_BRANCH: begin
            pc_wren     = 1'b1;
            sel_next_pc = branch_taken(inst_funct3, alu_zero) ? CTL_PC_IMM : CTL_PC_PLUS4;
            state_d     = CTL_ST_FETCH;
          end
          OPC_LOAD, OPC_STORE: state_d = CTL_ST_MEM;
          default:             state_d = CTL_ST_WB;
        endcase
      end
      CTL_ST_MEM: begin
        mem_rd_en = is_load;
        mem_wr_en = !is_load;
        if (mem_ready) begin
          if (is_load) begin
            state_d = CTL_ST_WB;
          end else begin
            pc_wren = 1'b1;
            state_d = CTL_ST_FETCH;
          end
        end else if (to_hit) begin
          state_d = CTL_ST_TRAP;
          cause_d = CTL_TRAP_DMEM_TO;
        end
      end
      CTL_ST_WB: begin
        reg_file_wen = 1'b1;
        pc_wren      = 1'b1;
        if (is_load) begin
          wb_sel = CTL_WB_MEM;
        end else if (is_jump) begin
          wb_sel      = CTL_WB_PC4;
          sel_next_pc = is_jal ? CTL_PC_IMM : CTL_PC_ALU;
        end
        state_d = CTL_ST_FETCH;
      end
      CTL_ST_TRAP: state_d = CTL_ST_TRAP;
      default:     state_d = CTL_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CTL_ST_IDLE;
      trap_q       <= 1'b0;
      trap_cause_q <= CTL_TRAP_NONE;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == CTL_ST_TRAP) && (state_q != CTL_ST_TRAP)) begin
        trap_q       <= 1'b1;
        trap_cause_q <= cause_d;
      end
      if ((state_d != state_q) && (state_d == CTL_ST_FETCH || state_d == CTL_ST_MEM)) begin
        cnt_q <= '0;
      end else if (waiting && TO_EN) begin
        cnt_q <= cnt_q + TO_W'(1);
      end
    end
  end

  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_controlpath_multi.sv
// tb/tb_controlpath_multi.sv - directed self-checking bench for controlpath_multi (MEM_TIMEOUT = 4)
module tb_controlpath_multi;

  logic       clk;
  logic       rst_n;
  logic [6:0] inst_opcode;
  logic [2:0] inst_funct3;
  logic [6:0] inst_funct7;
  logic       alu_zero;
  logic       imem_ready;
  logic       mem_ready;
  logic       imem_rd_en, ir_wren, pc_wren, reg_file_wen, mem_rd_en, mem_wr_en;
  logic [1:0] sel_next_pc, wb_sel, trap_cause;
  logic [3:0] alu_op;
  logic       alu_op_a_sel, alu_op_b_sel, trap;

  logic [5:0]  en;
  logic [18:0] all_out;
  int          vec;
  int          errs;

  assign en      = {imem_rd_en, ir_wren, pc_wren, reg_file_wen, mem_rd_en, mem_wr_en};
  assign all_out = {en, sel_next_pc, wb_sel, alu_op, alu_op_a_sel, alu_op_b_sel, trap, trap_cause};

  controlpath_multi #(
    .ALU_OP_W    (4),
    .MEM_TIMEOUT (4),
    .TO_W        (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_opcode  (inst_opcode),
    .inst_funct3  (inst_funct3),
    .inst_funct7  (inst_funct7),
    .alu_zero     (alu_zero),
    .imem_ready   (imem_ready),
    .mem_ready    (mem_ready),
    .imem_rd_en   (imem_rd_en),
    .ir_wren      (ir_wren),
    .pc_wren      (pc_wren),
    .sel_next_pc  (sel_next_pc),
    .alu_op       (alu_op),
    .alu_op_a_sel (alu_op_a_sel),
    .alu_op_b_sel (alu_op_b_sel),
    .reg_file_wen (reg_file_wen),
    .wb_sel       (wb_sel),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // leaves the bench at a falling edge with the DUT in IDLE (cycle 0)
  task automatic go_idle(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    inst_opcode = opc;
    inst_funct3 = f3;
    inst_funct7 = f7;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    inst_opcode = 7'b0110011; inst_funct3 = 3'b000; inst_funct7 = 7'b0;
    alu_zero = 1'b0; imem_ready = 1'b1; mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    vec++;
    if (all_out !== 19'd0) begin
      errs++; $display("FAIL reset_outputs: got %b expected %b", all_out, 19'd0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    vec++;
    if (all_out !== 19'd0) begin
      errs++; $display("FAIL idle_outputs: got %b expected %b", all_out, 19'd0);
    end
    @(negedge clk); #1;
    vec++;
    if (en !== 6'b110000) begin
      errs++; $display("FAIL first_fetch: got %b expected %b", en, 6'b110000);
    end
  endtask

  task automatic test_add();
    logic [5:0] exp_en [5];
    exp_en = '{6'b110000, 6'b000000, 6'b000000, 6'b001100, 6'b110000};
    imem_ready = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0;
    go_idle(7'b0110011, 3'b000, 7'b0000000);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      vec++;
      if ({en, sel_next_pc, wb_sel} !== {exp_en[c-1], 4'b0000}) begin
        errs++;
        $display("FAIL add_cycle%0d: got en=%b sel=%0d wb=%0d expected en=%b sel=0 wb=0",
                 c, en, sel_next_pc, wb_sel, exp_en[c-1]);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] t_opc [6];
    logic [2:0] t_f3  [6];
    logic [6:0] t_f7  [6];
    logic [5:0] t_exp [6];
    t_opc = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011};
    t_f3  = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b011, 3'b111};
    t_f7  = '{7'b0000000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0000000, 7'b0000000};
    // {alu_op, a_sel, b_sel}
    t_exp = '{{4'd0, 2'b00}, {4'd1, 2'b00}, {4'd0, 2'b01}, {4'd7, 2'b01},
              {4'd4, 2'b00}, {4'd9, 2'b00}};
    imem_ready = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      go_idle(t_opc[i], t_f3[i], t_f7[i]);
      repeat (3) @(negedge clk);
      #1;
      vec++;
      if ({alu_op, alu_op_a_sel, alu_op_b_sel} !== t_exp[i]) begin
        errs++;
        $display("FAIL alu_exec_%0d: got %b expected %b", i, {alu_op, alu_op_a_sel, alu_op_b_sel}, t_exp[i]);
      end
      @(negedge clk); #1;
      vec++;
      if ({en, alu_op, alu_op_a_sel, alu_op_b_sel} !== {6'b001100, t_exp[i]}) begin
        errs++;
        $display("FAIL alu_wb_%0d: got %b expected %b", i,
                 {en, alu_op, alu_op_a_sel, alu_op_b_sel}, {6'b001100, t_exp[i]});
      end
    end
  endtask

  task automatic test_load_wait();
    logic [5:0] exp_en [9];
    int rd_cycles;
    exp_en = '{6'b110000, 6'b000000, 6'b000000, 6'b000010, 6'b000010,
               6'b000010, 6'b000010, 6'b001100, 6'b110000};
    rd_cycles = 0;
    imem_ready = 1'b1; mem_ready = 1'b0;
    go_idle(7'b0000011, 3'b010, 7'b0000000);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      mem_ready = (c == 7);
      #1;
      if (mem_rd_en === 1'b1) rd_cycles++;
      vec++;
      if (en !== exp_en[c-1]) begin
        errs++; $display("FAIL lw_cycle%0d: got en=%b expected %b", c, en, exp_en[c-1]);
      end
      if (c == 8) begin
        vec++;
        if ({wb_sel, alu_op_b_sel, trap} !== 4'b0110) begin
          errs++; $display("FAIL lw_wb_sel: got %b expected %b", {wb_sel, alu_op_b_sel, trap}, 4'b0110);
        end
      end
    end
    mem_ready = 1'b0;
    vec++;
    if (rd_cycles != 4) begin
      errs++; $display("FAIL lw_rd_cycles: got %0d expected 4", rd_cycles);
    end
  endtask

  task automatic test_branch();
    logic [2:0] b_f3  [4];
    logic       b_z   [4];
    logic [1:0] b_sel [4];
    logic [3:0] b_op  [4];
    b_f3  = '{3'b000, 3'b001, 3'b100, 3'b111};
    b_z   = '{1'b1, 1'b1, 1'b0, 1'b0};
    b_sel = '{2'd1, 2'd0, 2'd1, 2'd0};
    b_op  = '{4'd1, 4'd1, 4'd3, 4'd4};
    imem_ready = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_zero = b_z[i];
      go_idle(7'b1100011, b_f3[i], 7'b0000000);
      repeat (3) @(negedge clk);
      #1;
      vec++;
      if ({en, sel_next_pc, alu_op, alu_op_b_sel} !== {6'b001000, b_sel[i], b_op[i], 1'b0}) begin
        errs++;
        $display("FAIL branch_exec_%0d: got %b expected %b", i,
                 {en, sel_next_pc, alu_op, alu_op_b_sel}, {6'b001000, b_sel[i], b_op[i], 1'b0});
      end
      @(negedge clk); #1;
      vec++;
      if (en !== 6'b110000) begin
        errs++; $display("FAIL branch_refetch_%0d: got %b expected %b", i, en, 6'b110000);
      end
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_illegal();
    imem_ready = 1'b1; mem_ready = 1'b1;
    go_idle(7'h7F, 3'b000, 7'b0000000);
    repeat (2) @(negedge clk);
    #1;
    vec++;
    if ({trap, en} !== 7'b0) begin
      errs++; $display("FAIL illegal_decode: got %b expected %b", {trap, en}, 7'b0);
    end
    for (int c = 0; c < 21; c++) begin
      @(negedge clk); #1;
      vec++;
      if (all_out !== 19'd5) begin
        errs++; $display("FAIL illegal_trap_hold%0d: got %b expected %b", c, all_out, 19'd5);
      end
    end
    mem_ready = 1'b0;
    go_idle(7'b1100011, 3'b010, 7'b0000000);
    repeat (3) @(negedge clk);
    #1;
    vec++;
    if ({en, trap, trap_cause} !== 9'b000000101) begin
      errs++; $display("FAIL illegal_branch: got %b expected %b", {en, trap, trap_cause}, 9'b000000101);
    end
    go_idle(7'b1101111, 3'b000, 7'b0000000);
    repeat (3) @(negedge clk);
    #1;
`ifdef CTL_JUMP_EN
    vec++;
    if ({en, alu_op, alu_op_a_sel, alu_op_b_sel, trap} !== {6'b0, 4'd0, 2'b11, 1'b0}) begin
      errs++; $display("FAIL jal_exec: got %b expected %b",
                       {en, alu_op, alu_op_a_sel, alu_op_b_sel, trap}, {6'b0, 4'd0, 2'b11, 1'b0});
    end
    @(negedge clk); #1;
    vec++;
    if ({en, wb_sel, sel_next_pc} !== {6'b001100, 2'd2, 2'd1}) begin
      errs++; $display("FAIL jal_wb: got %b expected %b", {en, wb_sel, sel_next_pc}, {6'b001100, 2'd2, 2'd1});
    end
`else
    vec++;
    if ({en, trap, trap_cause} !== 9'b000000101) begin
      errs++; $display("FAIL jal_disabled: got %b expected %b", {en, trap, trap_cause}, 9'b000000101);
    end
`endif
  endtask

  task automatic test_dmem_timeout();
    for (int run = 0; run < 2; run++) begin
      imem_ready = 1'b1; mem_ready = 1'b0;
      go_idle(7'b0100011, 3'b010, 7'b0000000);
      repeat (3) @(negedge clk);
      for (int c = 4; c <= 7; c++) begin
        @(negedge clk);
        mem_ready = (run == 1) && (c == 7);
        #1;
        vec++;
        if (en !== (((run == 1) && (c == 7)) ? 6'b001001 : 6'b000001)) begin
          errs++; $display("FAIL sw_wait_run%0d_c%0d: got en=%b", run, c, en);
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      vec++;
      if (run == 0) begin
        if ({en, trap, trap_cause} !== 9'b000000111) begin
          errs++; $display("FAIL sw_timeout: got %b expected %b", {en, trap, trap_cause}, 9'b000000111);
        end
      end else begin
        if ({en, trap, trap_cause} !== 9'b110000000) begin
          errs++; $display("FAIL sw_late_ready: got %b expected %b", {en, trap, trap_cause}, 9'b110000000);
        end
      end
    end
  endtask

  task automatic test_imem_timeout();
    imem_ready = 1'b0; mem_ready = 1'b0;
    go_idle(7'b0110011, 3'b000, 7'b0000000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      vec++;
      if ({en, trap} !== 7'b1000000) begin
        errs++; $display("FAIL imem_wait_c%0d: got %b expected %b", c, {en, trap}, 7'b1000000);
      end
    end
    @(negedge clk); #1;
    vec++;
    if ({en, trap, trap_cause} !== 9'b000000110) begin
      errs++; $display("FAIL imem_timeout: got %b expected %b", {en, trap, trap_cause}, 9'b000000110);
    end
    imem_ready = 1'b1;
  endtask

  task automatic test_reset_mid_mem();
    imem_ready = 1'b1; mem_ready = 1'b0;
    go_idle(7'b0000011, 3'b010, 7'b0000000);
    repeat (4) @(negedge clk);
    #1;
    vec++;
    if (en !== 6'b000010) begin
      errs++; $display("FAIL mid_mem_rd: got %b expected %b", en, 6'b000010);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (mem_rd_en !== 1'b0) begin
      errs++; $display("FAIL async_drop: got %b expected 0", mem_rd_en);
    end
    @(negedge clk); #1;
    vec++;
    if (all_out !== 19'd0) begin
      errs++; $display("FAIL in_reset: got %b expected %b", all_out, 19'd0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    vec++;
    if (all_out !== 19'd0) begin
      errs++; $display("FAIL post_reset_idle: got %b expected %b", all_out, 19'd0);
    end
    @(negedge clk); #1;
    vec++;
    if ({en, trap} !== 7'b1100000) begin
      errs++; $display("FAIL post_reset_fetch: got %b expected %b", {en, trap}, 7'b1100000);
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    rst_n = 1'b0;
    inst_opcode = 7'b0; inst_funct3 = 3'b0; inst_funct7 = 7'b0;
    alu_zero = 1'b0; imem_ready = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_add();
    test_alu_ops();
    test_load_wait();
    test_branch();
    test_illegal();
    test_dmem_timeout();
    test_imem_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
